// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 signed multiply.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [63:0] prod;
    logic [31:0] opd;
    logic        neg;
    logic [2:0]  f3;

    logic        signed_a, signed_b, sign_a, sign_b;
    logic [31:0] a_mag, b_mag;
    logic        is_div, div_zero, div_ovf, neg_in;
    logic [31:0] special_res;

    assign signed_a = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign signed_b = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign sign_a   = signed_a & a_i[31];
    assign sign_b   = signed_b & b_i[31];
    assign a_mag    = sign_a ? (~a_i + 32'd1) : a_i;
    assign b_mag    = sign_b ? (~b_i + 32'd1) : b_i;

    // Remainder follows the dividend's sign; everything else the xor of both signs.
    assign neg_in   = (funct3_i[2] & funct3_i[1]) ? sign_a : (sign_a ^ sign_b);

    assign is_div   = funct3_i[2];
    assign div_zero = is_div && (b_i == 32'd0);
    assign div_ovf  = is_div && !funct3_i[0] && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = funct3_i[1] ? a_i : 32'hFFFF_FFFF;
        else if (div_ovf)
            special_res = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [65:0] fast_prod;
    logic [31:0]        fast_res;
    assign fast_prod = $signed({sign_a, a_i}) * $signed({sign_b, b_i});
    assign fast_res  = (funct3_i[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
`endif

    // One iteration step; prod holds {acc, multiplier} for MUL and {rem, quotient} for DIV.
    logic [32:0] add_sum, shifted, sub_diff;
    logic [63:0] mul_next, div_next, step_next;
    logic [31:0] mul_res, div_val, div_res, final_res;

    assign add_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opd} : 33'd0);
    assign mul_next = {add_sum, prod[31:1]};
    assign shifted  = {prod[63:32], prod[31]};
    assign sub_diff = shifted - {1'b0, opd};
    assign div_next = sub_diff[32] ? {shifted[31:0], prod[30:0], 1'b0}
                                   : {sub_diff[31:0], prod[30:0], 1'b1};
    assign step_next = f3[2] ? div_next : mul_next;

    // High word of a negated 64-bit product: carry in only when the low word is zero.
    always_comb begin
        mul_res = mul_next[63:32];
        if (f3[1:0] == 2'b00)
            mul_res = mul_next[31:0];
        else if (neg)
            mul_res = ~mul_next[63:32] + {31'd0, (mul_next[31:0] == 32'd0)};
    end

    assign div_val   = f3[1] ? div_next[63:32] : div_next[31:0];
    assign div_res   = neg ? (~div_val + 32'd1) : div_val;
    assign final_res = f3[2] ? div_res : mul_res;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            prod     <= 64'd0;
            opd      <= 32'd0;
            neg      <= 1'b0;
            f3       <= 3'd0;
            result_o <= 32'd0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        f3  <= funct3_i;
                        neg <= neg_in;
                        cnt <= 6'd0;
                        if (is_div) begin
                            opd  <= b_mag;
                            prod <= {32'd0, a_mag};
                            if (div_zero || div_ovf) begin
                                result_o <= special_res;
                                state    <= DONE;
                            end else begin
                                state <= DIV;
                            end
                        end else begin
                            opd  <= a_mag;
                            prod <= {32'd0, b_mag};
`ifdef MULDIV_FAST_MUL_EN
                            result_o <= fast_res;
                            state    <= DONE;
`else
                            state    <= MUL;
`endif
                        end
                    end
                end
                MUL, DIV: begin
                    prod <= step_next;
                    cnt  <= (cnt == 6'd32) ? cnt : cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        result_o <= final_res;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_o = rst && (((state == IDLE) && start_i && !flush_i) ||
                             (state == MUL) || (state == DIV));
    assign done_o  = rst && (state == DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: latency, stall length, results, special cases, flush and reset.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    ex_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present an op, hold start until accepted, then time done_o and count stall cycles.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        int stalls;
        bit seen;
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        funct3_i = f3;
        a_i      = a;
        b_i      = b;
        cyc      = 0;
        stalls   = 0;
        seen     = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (done_o) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                start_i = 1'b0;
                cyc++;
            end
        end
        check({tag, ".done"}, 32'(seen), 32'd1);
        check({tag, ".lat"}, 32'(cyc), 32'(lat));
        check({tag, ".stall"}, 32'(stalls), 32'(lat));
        check({tag, ".res"}, result_o, exp);
        @(negedge clk);
        check({tag, ".done_once"}, 32'(done_o), 32'd0);
        check({tag, ".hold"}, result_o, exp);
    endtask

    initial begin
        int done_cnt;

        // Reset overrides start: no stall, no done.
        rst     = 1'b0;
        start_i = 1'b1;
        a_i     = 32'd9;
        b_i     = 32'd3;
        @(negedge clk);
        check("rst.stall", 32'(stall_o), 32'd0);
        check("rst.done", 32'(done_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst.result", result_o, 32'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("idle.stall", 32'(stall_o), 32'd0);
        check("idle.done", 32'(done_o), 32'd0);

        run_op("mul_7_m3",   F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_max",  F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_m1",    F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("mulh_min",   F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu",     F_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("mul_low",    F_MUL,    32'h1234_5678,  32'h10,        32'h2345_6780, MUL_LAT);
        run_op("div_m7_2",   F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",   F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("div_7_m2",   F_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2",   F_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33);
        run_op("div_min_1",  F_DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 33);
        run_op("remu_100_7", F_REMU,   32'd100,        32'd7,         32'd2,         33);
        run_op("divu_5_0",   F_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_5_0",   F_REMU,   32'd5,          32'd0,         32'd5,         1);
        run_op("div_m7_0",   F_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_m7_0",   F_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1);
        run_op("div_ovf",    F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Flush beats a simultaneous start in IDLE.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        flush_i  = 1'b1;
        funct3_i = F_DIVU;
        a_i      = 32'd50;
        b_i      = 32'd5;
        @(negedge clk);
        check("flush_start.stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_start.done", 32'(done_o), 32'd0);
        check("flush_start.stall2", 32'(stall_o), 32'd0);
        check("flush_start.res", result_o, 32'd0);

        // Flush at step 10 of a DIV.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        funct3_i = F_DIV;
        a_i      = 32'd1000;
        b_i      = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_div.stall_busy", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_div.done", 32'(done_o), 32'd0);
        check("flush_div.stall", 32'(stall_o), 32'd0);
        check("flush_div.res", result_o, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        check("flush_div.no_done", 32'(done_cnt), 32'd0);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);

        // Reset arriving mid-operation.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        funct3_i = F_DIVU;
        a_i      = 32'd77;
        b_i      = 32'd4;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst.stall", 32'(stall_o), 32'd0);
        check("midrst.done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst.res", result_o, 32'd0);
        check("midrst.idle", 32'(stall_o), 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        check("midrst.no_done", 32'(done_cnt), 32'd0);
        run_op("divu_post_rst", F_DIVU, 32'd77, 32'd4, 32'd19, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
